// File: rtl/tlul_sram_bridge.sv
// TL-UL device responder in front of a single-port SRAM: classifies A-channel
// requests, issues SRAM accesses and returns in-order D-channel responses.

package tlul_pkg;
    localparam logic [2:0] OpPutFull       = 3'h0;
    localparam logic [2:0] OpPutPartial    = 3'h1;
    localparam logic [2:0] OpGet           = 3'h4;
    localparam logic [2:0] OpAccessAck     = 3'h0;
    localparam logic [2:0] OpAccessAckData = 3'h1;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Inverted 7-way parity fold, so an all-zero bus never carries valid integrity.
    function automatic logic [6:0] fold7(input logic [63:0] v);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[3'(i % 7)] = r[3'(i % 7)] ^ v[i];
        return ~r;
    endfunction

    function automatic logic [6:0] cmd_intg_gen(input logic [2:0] op, input logic [31:0] addr,
                                                 input logic [3:0] mask);
        return fold7({25'b0, op, addr, mask});
    endfunction

    function automatic logic [6:0] data_intg_gen(input logic [31:0] data);
        return fold7({32'b0, data});
    endfunction

    function automatic logic [6:0] rsp_intg_gen(input logic [2:0] op, input logic [1:0] size,
                                                 input logic err);
        return fold7({58'b0, op, size, err});
    endfunction
endpackage

module tlul_sram_bridge
    import tlul_pkg::*;
#(
    parameter int unsigned SramAw      = 10,
    parameter logic [31:0] BaseAddr    = 32'h0010_0000,
    parameter int unsigned Outstanding = 2,
    parameter logic [31:0] ErrData     = 32'hFFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [SramAw-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    output logic [31:0]       sram_wmask_o,
    input  logic [31:0]       sram_rdata_i
);
    localparam int unsigned   PtrW    = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int unsigned   CntW    = $clog2(Outstanding + 1);
    localparam logic [CntW-1:0] Depth = CntW'(Outstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Outstanding - 1);

    typedef struct packed {
        logic        valid;
        logic [2:0]  opcode;
        logic [7:0]  source;
        logic [1:0]  size;
        logic        error;
        logic [31:0] data;
        logic        data_ok;
    } entry_t;

    entry_t          fifo_q [Outstanding];
    entry_t          fifo_d [Outstanding];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rd_idx_q, rd_idx_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rd_pend_q, rd_pend_d;

    logic   a_ready, accept, is_get, req_err, d_valid, pop;
    entry_t head;
    logic   unused_a_param;

    assign unused_a_param = ^tl_i.a_param;

    assign a_ready = !rst_i && (count_q < Depth);
    assign accept  = tl_i.a_valid && a_ready;
    assign is_get  = (tl_i.a_opcode == OpGet);

    always_comb begin
        req_err = 1'b0;
        if ((tl_i.a_address >> (SramAw + 2)) != (BaseAddr >> (SramAw + 2))) req_err = 1'b1;
        if (tl_i.a_address[1:0] != 2'b00) req_err = 1'b1;
        if (!(tl_i.a_opcode inside {OpGet, OpPutFull, OpPutPartial})) req_err = 1'b1;
        if (tl_i.a_opcode == OpPutFull && tl_i.a_mask != 4'hF) req_err = 1'b1;
        if (tl_i.a_user.cmd_intg != cmd_intg_gen(tl_i.a_opcode, tl_i.a_address, tl_i.a_mask))
            req_err = 1'b1;
        if (tl_i.a_user.data_intg != data_intg_gen(tl_i.a_data)) req_err = 1'b1;
    end

    assign sram_req_o   = accept && !req_err;
    assign sram_we_o    = !is_get;
    assign sram_addr_o  = tl_i.a_address[SramAw+1:2];
    assign sram_wdata_o = tl_i.a_data;
    assign sram_wmask_o = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                           {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};

    // Read data arriving this cycle for the head is forwarded, giving 1-cycle Get latency.
    always_comb begin
        head = fifo_q[rptr_q];
        if (rd_pend_q && rd_idx_q == rptr_q) begin
            head.data    = sram_rdata_i;
            head.data_ok = 1'b1;
        end
    end

    assign d_valid = !rst_i && head.valid && head.data_ok;
    assign pop     = d_valid && tl_i.d_ready;

    always_comb begin
        tl_o                  = '0;
        tl_o.a_ready          = a_ready;
        tl_o.d_valid          = d_valid;
        tl_o.d_opcode         = head.opcode;
        tl_o.d_size           = head.size;
        tl_o.d_source         = head.source;
        tl_o.d_error          = head.error;
        tl_o.d_data           = head.data;
        tl_o.d_user.rsp_intg  = rsp_intg_gen(head.opcode, head.size, head.error);
        tl_o.d_user.data_intg = data_intg_gen(head.data);
    end

    always_comb begin
        fifo_d = fifo_q;
        if (rd_pend_q) begin
            fifo_d[rd_idx_q].data    = sram_rdata_i;
            fifo_d[rd_idx_q].data_ok = 1'b1;
        end
        if (pop) fifo_d[rptr_q].valid = 1'b0;
        if (accept) begin
            fifo_d[wptr_q].valid   = 1'b1;
            fifo_d[wptr_q].opcode  = is_get ? OpAccessAckData : OpAccessAck;
            fifo_d[wptr_q].source  = tl_i.a_source;
            fifo_d[wptr_q].size    = tl_i.a_size;
            fifo_d[wptr_q].error   = req_err;
            fifo_d[wptr_q].data    = (is_get && req_err) ? ErrData : 32'h0;
            fifo_d[wptr_q].data_ok = !(is_get && !req_err);
        end

        rd_pend_d = accept && is_get && !req_err;
        rd_idx_d  = wptr_q;

        wptr_d = wptr_q;
        if (accept) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        rptr_d = rptr_q;
        if (pop) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;

        count_d = count_q;
        if (accept && !pop) count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Outstanding; i++) fifo_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_idx_q  <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_idx_q  <= rd_idx_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
        end
    end
endmodule
